// File: rtl/evm_stack.sv
// EVM operand stack: DEPTH x 256-bit words with the top WIN entries exposed combinationally.
// Instruction commits are checked in IDLE, and result words are written back one per cycle.
module evm_stack #(
  parameter int DEPTH = 1024,
  parameter int WIN   = 17
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   commit_valid,
  output logic                   commit_ready,
  input  logic [4:0]             pop_num,
  input  logic [4:0]             push_num,
  input  logic [0:WIN-1][255:0]  data_in,
  input  logic                   exit,
  output logic [0:WIN-1][255:0]  stack_data,
  output logic [$clog2(DEPTH):0] stack_height,
  output logic                   fault,
  output logic [1:0]             fault_code
);
  localparam int AW = $clog2(DEPTH);
  localparam int HW = AW + 1;
  localparam int XW = HW + 1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                state_q, state_d;
  logic [HW-1:0]         height_q, height_d;
  logic [HW-1:0]         base_q, base_d;
  logic [4:0]            pushCnt_q, pushCnt_d;
  logic [4:0]            wordIdx_q, wordIdx_d;
  logic                  fault_q, fault_d;
  logic [1:0]            faultCode_q, faultCode_d;
  logic [0:WIN-1][255:0] latch_q;
  logic [255:0]          mem_q [DEPTH];
  logic                  latchEn;
  logic                  memWe;
  logic [AW-1:0]         wrAddr;
  logic [XW-1:0]         heightExt, popExt, pushExt, newHeight;

  // One bit wider than the height, so the overflow check cannot wrap
  assign heightExt = XW'(height_q);
  assign popExt    = XW'(pop_num);
  assign pushExt   = XW'(push_num);
  assign newHeight = heightExt - popExt + pushExt;

  // Word k of the result lands at base+p-1-k, so data_in[0] ends up on top
  assign wrAddr = AW'(base_q + HW'(pushCnt_q) - HW'(wordIdx_q) - HW'(1));

  always_comb begin
    state_d     = state_q;
    height_d    = height_q;
    base_d      = base_q;
    pushCnt_d   = pushCnt_q;
    wordIdx_d   = wordIdx_q;
    fault_d     = 1'b0;
    faultCode_d = faultCode_q;
    latchEn     = 1'b0;
    memWe       = 1'b0;
    case (state_q)
      IDLE: begin
        if (commit_valid) begin
          if (exit) begin
            fault_d     = 1'b1;
            faultCode_d = 2'b11;
          end else if (popExt > heightExt) begin
            fault_d     = 1'b1;
            faultCode_d = 2'b01;
          end else if (newHeight > XW'(DEPTH)) begin
            fault_d     = 1'b1;
            faultCode_d = 2'b10;
          end else if (push_num == 5'd0) begin
            height_d = height_q - HW'(pop_num);
          end else begin
            base_d    = height_q - HW'(pop_num);
            pushCnt_d = push_num;
            wordIdx_d = 5'd0;
            latchEn   = 1'b1;
            state_d   = WRITE;
          end
        end
      end
      WRITE: begin
        memWe     = 1'b1;
        wordIdx_d = wordIdx_q + 5'd1;
        if (wordIdx_q == pushCnt_q - 5'd1) begin
          height_d = base_q + HW'(pushCnt_q);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      height_q    <= '0;
      base_q      <= '0;
      pushCnt_q   <= '0;
      wordIdx_q   <= '0;
      fault_q     <= 1'b0;
      faultCode_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      height_q    <= height_d;
      base_q      <= base_d;
      pushCnt_q   <= pushCnt_d;
      wordIdx_q   <= wordIdx_d;
      fault_q     <= fault_d;
      faultCode_q <= faultCode_d;
    end
  end

  // Storage is deliberately not reset; the height alone decides what is visible
  always_ff @(posedge clk) begin
    if (latchEn) latch_q <= data_in;
    if (memWe) mem_q[wrAddr] <= latch_q[wordIdx_q];
  end

  for (genvar g = 0; g < WIN; g++) begin : gRead
    logic [AW-1:0] rdAddr;
    assign rdAddr        = AW'(height_q - HW'(g + 1));
    assign stack_data[g] = (height_q > HW'(g)) ? mem_q[rdAddr] : '0;
  end

  assign commit_ready = (state_q == IDLE);
  assign stack_height = height_q;
  assign fault        = fault_q;
  assign fault_code   = faultCode_q;

endmodule

// File: tb/tb_evm_stack.sv
// Self-checking bench for evm_stack: a table of commits plus hand-written boundary sequences.
// A reference stack model scores every commit.
module tb_evm_stack;
  localparam int DEPTH = 1024;
  localparam int WIN   = 17;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  commit_valid;
  logic                  commit_ready;
  logic [4:0]            pop_num;
  logic [4:0]            push_num;
  logic [0:WIN-1][255:0] data_in;
  logic                  exit;
  logic [0:WIN-1][255:0] stack_data;
  logic [10:0]           stack_height;
  logic                  fault;
  logic [1:0]            fault_code;

  always #5 clk = ~clk;

  evm_stack #(.DEPTH(DEPTH), .WIN(WIN)) dut (
    .clk          (clk),
    .rst          (rst),
    .commit_valid (commit_valid),
    .commit_ready (commit_ready),
    .pop_num      (pop_num),
    .push_num     (push_num),
    .data_in      (data_in),
    .exit         (exit),
    .stack_data   (stack_data),
    .stack_height (stack_height),
    .fault        (fault),
    .fault_code   (fault_code)
  );

  typedef struct {
    logic [4:0]            pop;
    logic [4:0]            push;
    logic                  ex;
    logic [0:WIN-1][255:0] data;
    int                    expHeight;
    logic [1:0]            expCode;
  } vec_t;

  typedef struct {
    logic                  fault;
    logic [1:0]            code;
    int                    height;
    int                    lowCycles;
    logic [0:WIN-1][255:0] top;
  } exp_t;

  exp_t         sbQ[$];
  logic [255:0] modelMem [DEPTH];
  int           modelHeight;
  logic [1:0]   modelCode;
  int           checks   = 0;
  int           failures = 0;

  task automatic checkVal(input string name, input logic [255:0] act, input logic [255:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic vec_t mkVec(input int pop, input int push, input logic ex,
                                 input logic [255:0] d0, input logic [255:0] d1,
                                 input logic [255:0] d2, input int expH, input logic [1:0] expC);
    vec_t v;
    v.pop       = 5'(pop);
    v.push      = 5'(push);
    v.ex        = ex;
    v.data      = '0;
    v.data[0]   = d0;
    v.data[1]   = d1;
    v.data[2]   = d2;
    v.expHeight = expH;
    v.expCode   = expC;
    return v;
  endfunction

  // Reference model applies the acceptance rules and queues the expected outcome
  task automatic modelCommit(input vec_t v);
    exp_t e;
    int   base;
    e.fault     = 1'b0;
    e.lowCycles = 0;
    if (v.ex) begin
      e.fault   = 1'b1;
      modelCode = 2'b11;
    end else if (int'(v.pop) > modelHeight) begin
      e.fault   = 1'b1;
      modelCode = 2'b01;
    end else if (modelHeight - int'(v.pop) + int'(v.push) > DEPTH) begin
      e.fault   = 1'b1;
      modelCode = 2'b10;
    end else begin
      base = modelHeight - int'(v.pop);
      for (int k = 0; k < int'(v.push); k++) modelMem[base + int'(v.push) - 1 - k] = v.data[k];
      modelHeight = base + int'(v.push);
      e.lowCycles = int'(v.push);
    end
    e.code   = modelCode;
    e.height = modelHeight;
    for (int i = 0; i < WIN; i++) e.top[i] = (i < modelHeight) ? modelMem[modelHeight - 1 - i] : '0;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    exp_t e;
    int   low = 0;
    e = sbQ.pop_front();
    checkVal({tag, " fault pulse"}, 256'(fault), 256'(e.fault));
    while (!commit_ready && low < 40) begin
      low++;
      @(posedge clk); #1;
    end
    checkVal({tag, " ready-low cycles"}, 256'(low), 256'(e.lowCycles));
    @(posedge clk); #1;
    checkVal({tag, " fault after pulse"}, 256'(fault), 256'(0));
    checkVal({tag, " height"}, 256'(stack_height), 256'(e.height));
    checkVal({tag, " fault_code"}, 256'(fault_code), 256'(e.code));
    if (v.expHeight >= 0) begin
      checkVal({tag, " table height"}, 256'(stack_height), 256'(v.expHeight));
      checkVal({tag, " table code"}, 256'(fault_code), 256'(v.expCode));
    end
    for (int i = 0; i < WIN; i++)
      checkVal($sformatf("%s stack_data[%0d]", tag, i), stack_data[i], e.top[i]);
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge clk);
    commit_valid = 1'b1;
    pop_num      = v.pop;
    push_num     = v.push;
    exit         = v.ex;
    data_in      = v.data;
    modelCommit(v);
    @(posedge clk); #1;
    commit_valid = 1'b0;
    exit         = 1'b0;
    data_in      = '0;
    checkOutput(v, tag);
  endtask

  vec_t tbl[14];
  vec_t v;

  initial begin
    rst          = 1'b1;
    commit_valid = 1'b0;
    pop_num      = '0;
    push_num     = '0;
    exit         = 1'b0;
    data_in      = '0;
    modelHeight  = 0;
    modelCode    = 2'b00;

    tbl[0]  = mkVec(0, 1, 1'b0, 256'hA, 0, 0, 1, 2'b00);
    tbl[1]  = mkVec(0, 1, 1'b0, 256'hB, 0, 0, 2, 2'b00);
    tbl[2]  = mkVec(0, 1, 1'b0, 256'hC, 0, 0, 3, 2'b00);
    tbl[3]  = mkVec(3, 3, 1'b0, 256'hA, 256'hB, 256'hC, 3, 2'b00);
    tbl[4]  = mkVec(2, 1, 1'b0, 256'h5, 0, 0, 2, 2'b00);
    tbl[5]  = mkVec(1, 0, 1'b0, 0, 0, 0, 1, 2'b00);
    tbl[6]  = mkVec(2, 0, 1'b0, 0, 0, 0, 1, 2'b01);
    tbl[7]  = mkVec(0, 1, 1'b1, 256'h7, 0, 0, 1, 2'b11);
    tbl[8]  = mkVec(0, 1, 1'b0, 256'h9, 0, 0, 2, 2'b11);
    tbl[9]  = mkVec(1, 0, 1'b0, 0, 0, 0, 1, 2'b11);
    tbl[10] = mkVec(1, 1, 1'b0, 256'h1234, 0, 0, 1, 2'b11);
    tbl[11] = mkVec(1, 0, 1'b0, 0, 0, 0, 0, 2'b11);
    tbl[12] = mkVec(1, 0, 1'b0, 0, 0, 0, 0, 2'b01);
    tbl[13] = mkVec(0, 17, 1'b0, 0, 0, 0, 17, 2'b01);
    for (int k = 0; k < WIN; k++) tbl[13].data[k] = rand256();

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkVal("reset height", 256'(stack_height), 256'(0));
    checkVal("reset ready", 256'(commit_ready), 256'(1));
    checkVal("reset fault", 256'(fault), 256'(0));
    checkVal("reset fault_code", 256'(fault_code), 256'(0));
    for (int i = 0; i < WIN; i++) checkVal($sformatf("reset stack_data[%0d]", i), stack_data[i], '0);

    for (int n = 0; n < 14; n++) applyStimulus(tbl[n], $sformatf("vec%0d", n));

    // Fill from 17 entries to exactly DEPTH
    for (int n = 0; n < 59; n++) begin
      v = mkVec(0, 17, 1'b0, 0, 0, 0, -1, 2'b00);
      for (int k = 0; k < WIN; k++) v.data[k] = rand256();
      applyStimulus(v, $sformatf("fill%0d", n));
    end
    v = mkVec(0, 4, 1'b0, rand256(), rand256(), rand256(), 1024, 2'b01);
    v.data[3] = rand256();
    applyStimulus(v, "fillLast");

    applyStimulus(mkVec(0, 1, 1'b0, 256'hDEAD, 0, 0, 1024, 2'b10), "fullPush");
    applyStimulus(mkVec(1, 1, 1'b0, 256'hBEEF, 0, 0, 1024, 2'b10), "fullSwap1");
    v = mkVec(17, 17, 1'b0, 0, 0, 0, 1024, 2'b10);
    for (int k = 0; k < WIN; k++) v.data[k] = rand256();
    applyStimulus(v, "fullSwap17");
    applyStimulus(mkVec(1, 0, 1'b1, 0, 0, 0, 1024, 2'b11), "exitLegal");

    // Zero-push commits held valid are accepted on consecutive edges
    @(negedge clk);
    commit_valid = 1'b1;
    pop_num      = 5'd1;
    push_num     = 5'd0;
    @(posedge clk); #1;
    checkVal("b2b first height", 256'(stack_height), 256'(1023));
    checkVal("b2b first ready", 256'(commit_ready), 256'(1));
    @(posedge clk); #1;
    commit_valid = 1'b0;
    pop_num      = 5'd0;
    modelHeight  = modelHeight - 2;
    checkVal("b2b second height", 256'(stack_height), 256'(1022));
    checkVal("b2b top", stack_data[0], modelMem[1021]);

    // Reset during the second write cycle of a push-3 commit
    @(negedge clk);
    commit_valid = 1'b1;
    pop_num      = 5'd3;
    push_num     = 5'd3;
    data_in      = '0;
    data_in[0]   = 256'h111;
    data_in[1]   = 256'h222;
    data_in[2]   = 256'h333;
    @(posedge clk); #1;
    commit_valid = 1'b0;
    checkVal("midwrite ready low", 256'(commit_ready), 256'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkVal("midwrite reset height", 256'(stack_height), 256'(0));
    checkVal("midwrite reset ready", 256'(commit_ready), 256'(1));
    checkVal("midwrite reset top", stack_data[0], '0);
    @(negedge clk);
    rst         = 1'b0;
    modelHeight = 0;
    modelCode   = 2'b00;
    applyStimulus(mkVec(0, 1, 1'b0, 256'hEE, 0, 0, 1, 2'b00), "afterReset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/evm_stack.md
# evm_stack

EVM operand stack: holds up to DEPTH 256-bit words and presents the top 17 entries plus the current height to the instruction units (swap, dup, arithmetic). It also accepts each instruction's commit (pop count, push count, result words) and writes the results back. It sits directly upstream and downstream of every instruction unit, sourcing `stack_data`/`stack_height` and consuming `data_out`/`pop_num`/`push_num`/`exit`. Write-back is sequential, one word per cycle, behind a valid/ready handshake.

## Interface
Parameters:
- DEPTH, 1024, maximum stack entries (EVM limit).
- WIN, 17, number of top entries exposed and maximum push/pop per commit.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- commit_valid  in  1  instruction unit presents a commit.
- commit_ready  out  1  block can accept a commit (IDLE state).
- pop_num  in  5  entries consumed by the instruction (0..17).
- push_num  in  5  entries produced by the instruction (0..17).
- data_in  in  256 x [0:16]  result words; `data_in[0]` becomes the new top.
- exit  in  1  instruction raised an exception; commit is rejected.
- stack_data  out  256 x [0:16]  `stack_data[i]` = entry i below the top; zero when i >= height.
- stack_height  out  11  current entry count (0..DEPTH).
- fault  out  1  one-cycle pulse on a rejected commit.
- fault_code  out  2  01 underflow, 10 overflow, 11 exit; held until the next fault.

## Operation
- Storage: DEPTH x 256 register array. Entry at address a (0 = bottom). Top is at address height-1.
  - `stack_data[i]` = mem[height-1-i] if i < height, else 0.
  - Combinational from the registered height and memory.
- States:
  - IDLE: `commit_ready`=1.
  - WRITE: `commit_ready`=0, counter k.
- Acceptance in IDLE (commit_valid & commit_ready), checked in priority order:
  - exit=1: reject, code 11.
  - pop_num > height: reject, code 01.
  - height - pop_num + push_num > DEPTH: reject, code 10. Arithmetic is 12-bit unsigned, so there is no wrap.
  - otherwise: accept.
- Reject: `fault` pulses for one cycle, `fault_code` updates, height and memory are unchanged, and the block stays in IDLE.
- Accept with push_num=0: height <= height - pop_num at the accept edge; stay IDLE.
- Accept with push_num=p>0:
  - At the accept edge, latch base = height - pop_num, p, and data_in[0..p-1]; enter WRITE with k=0.
  - Each WRITE cycle writes mem[base+p-1-k] <= latched data_in[k], then k++.
  - On the edge that writes k=p-1, height <= base+p and the state returns to IDLE.
- Entries below base are never rewritten. pop-then-push of the same slot is therefore handled by the overwrite alone.
- commit_valid while not ready is ignored; the producer holds the commit until the handshake completes.
- `data_in[p..16]` are ignored.

## Timing
- Reset values:
  - height=0, state IDLE, commit_ready=1, fault=0, fault_code=00.
  - `stack_data` all 0.
  - Memory is not cleared.
- Reset asserted mid-WRITE aborts the write: height returns to 0 asynchronously, and partially written entries are invisible.
- Commit latency:
  - push 0: 1 edge.
  - push p: p edges after the accept edge; commit_ready is low for exactly p cycles.
- `stack_data`/`stack_height` are stable and valid only in IDLE. During WRITE they show the pre-commit height, so consumers must not sample them.
- fault is high exactly in the cycle after the rejecting edge.
- Throughput: back-to-back zero-push commits are accepted every cycle.
- Full boundary: height=DEPTH with push=pop is accepted. push > pop at DEPTH faults with code 10.
- Empty boundary: height=0 with pop=0, push=1 is accepted. Any pop>0 at height 0 faults with code 01.

## Test plan
- Reset, then 3 commits (pop 0, push 1, data 0xA/0xB/0xC):
  - stack_height=3; stack_data[0..2]=C,B,A; stack_data[3]=0.
  - commit_ready low for 1 cycle per commit.
- Swap-style commit on stack C,B,A (pop 3, push 3, data A,B,C):
  - ready low 3 cycles; height stays 3; stack_data[0..2]=A,B,C.
- Add-style commit (pop 2, push 1, data 0x5) on height 3:
  - height=2; top=0x5; rest unchanged.
- Height 1, commit pop 2 → fault pulse, code 01, height 1, contents unchanged.
- Fill to 1024, then:
  - push 1, pop 0 → code 10.
  - pop 1, push 1 → accepted.
- exit=1 together with a valid legal commit → code 11, no change.
- Reset asserted during the 2nd WRITE cycle of a push-3 commit → height 0, ready 1 immediately.
